// File: rtl/cipher_packer.sv
// Packs a serial ciphertext bit stream MSB-first into WIDTH-bit words and
// queues them in a show-ahead FIFO drained through a valid/ready handshake.
module cipher_packer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       bit_in,
   input  logic                       bit_valid,
   input  logic                       flush,
   output logic [WIDTH-1:0]           word_out,
   output logic                       word_valid,
   input  logic                       word_ready,
   output logic [$clog2(DEPTH):0]     fill,
   output logic [$clog2(WIDTH)-1:0]   bit_count,
   output logic                       overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam int PW = $clog2(DEPTH);
   localparam int FW = PW + 1;
   localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
   localparam logic [CW:0]   W_C    = (CW + 1)'(WIDTH);
   localparam logic [FW-1:0] FULL_C = FW'(DEPTH);

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] sh_acc;
   logic [WIDTH-1:0] push_word;
   logic [CW:0]      cnt_acc;
   logic             complete;
   logic             push;
   logic             pop;
   logic             full;
   logic             wr_en;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;

   // A bit arriving with flush is absorbed first, so flush sees the post-bit count.
   always_comb begin
      sh_acc    = bit_valid ? {shreg[WIDTH-2:0], bit_in} : shreg;
      cnt_acc   = {1'b0, bit_count} + {{CW{1'b0}}, bit_valid};
      complete  = bit_valid && (bit_count == LAST);
      push      = complete || (flush && (cnt_acc != '0));
      push_word = complete ? sh_acc : (sh_acc << (W_C - cnt_acc));
      pop       = word_valid && word_ready;
      full      = (fill == FULL_C);
      wr_en     = push && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg     <= '0;
         bit_count <= '0;
         fill      <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         overflow  <= 1'b0;
      end else begin
         shreg <= sh_acc;
         if (push)
            bit_count <= '0;
         else if (bit_valid)
            bit_count <= bit_count + 1'b1;
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && full && !pop)
            overflow <= 1'b1;
         case ({wr_en, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_en)
         mem[wr_ptr] <= push_word;
   end

   assign word_valid = (fill != '0);
   assign word_out   = word_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/cipher_packer.md
# cipher_packer

Downstream stage of the ChaCha20 bit-serial encrypter: consumes the one-bit ciphertext stream produced by `main` (`final_output`) and packs it MSB-first into WIDTH-bit words. Completed words go into a small show-ahead FIFO drained through a valid/ready handshake, so a host or UART can read ciphertext a word at a time. A flush input closes a partial word by zero-padding it.

## Interface
- WIDTH, 8, word width in bits; legal range 2..16.
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  ciphertext bit, driven from `main.final_output`.
- bit_valid  in  1  bit_in is sampled on this edge.
- flush  in  1  close the current partial word.
- word_out  out  WIDTH  FIFO head word.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accepts word_out this edge.
- fill  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- bit_count  out  clog2(WIDTH)  bits held in the assembly register, 0..WIDTH-1.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

## Operation
- Assembly register shreg[WIDTH-1:0], counter bit_count. On bit_valid: shreg <= {shreg[WIDTH-2:0], bit_in}; bit_count+1.
- First bit of a word lands in word_out[WIDTH-1] (MSB-first).
- Word complete when bit_valid and bit_count==WIDTH-1: the full word is pushed on that edge, and bit_count -> 0.
- flush with bit_count>0 (counting a bit accepted on the same edge): push the accumulated bits left-aligned, low bits zero; bit_count -> 0.
- flush and bit_valid together: the bit is accepted first, then the word is padded and pushed. If that bit completes the word, exactly one word is pushed, unpadded.
- flush with bit_count==0 and no bit_valid: no-op; no empty word is pushed.
- Pop when word_valid && word_ready; the head advances.
- Push when fill==DEPTH with no pop on the same edge: the word is dropped, overflow <= 1, bit_count still -> 0, FIFO contents are unchanged.
- Push and pop on the same edge while full: both take effect; fill stays DEPTH; no overflow.
- Push and pop on the same edge while empty: not possible, because word_valid is 0.
- overflow clears only on reset.
- FIFO uses circular read/write pointers that wrap modulo DEPTH. fill is tracked with an explicit counter, not derived from pointer difference.
- Reset (synchronous, takes priority over all inputs):
  - bit_count=0, fill=0, overflow=0, pointers=0.
  - word_valid=0, word_out=0.
  - bit_valid, flush and word_ready on the reset edge are ignored.
- Reset mid-word or with a non-empty FIFO discards everything.

## Timing
- bit_in/bit_valid are sampled on the rising edge.
- Latency: word_valid and word_out present the word on the cycle after the edge that completes or flushes it, when the FIFO was empty.
- Show-ahead FIFO: the head is visible with no read latency. word_out and word_valid are registered or driven directly from FIFO storage, with no combinational path from bit_in/word_ready.
- Holding rule: while word_valid && !word_ready, word_out holds stable.
- Upstream pacing: `main` produces at most one bit per plaintext strobe. bit_valid may be asserted every cycle, and throughput is one bit per cycle.
- fill, bit_count and overflow update on the same edge as the event that causes them.

## Test plan
- After reset, bits 1,0,1,1,0,0,1,0 on consecutive bit_valid cycles, word_ready=0 -> the cycle after the 8th edge: word_valid=1, word_out=8'hB2, fill=1, bit_count=0.
- Bits 1,1,1, then flush alone -> word_out=8'hE0, fill=1. A second flush with bit_count=0 -> fill stays 1.
- Bits 1,0, then bit_valid=1/bit_in=1 with flush on the same edge -> one word 8'hA0, bit_count=0. Separately: 7 bits 1111111, then bit_in=0 with flush -> single word 8'hFE, fill=1.
- word_ready=0, push 5 words 8'h01..8'h05 -> fill=4, overflow=1. Then word_ready=1 drains 8'h01,8'h02,8'h03,8'h04 in order, after which word_valid=0.
- FIFO full, word_ready=1, and a word completes on the same edge -> fill stays 4, overflow stays 0, and the new word appears after the three older ones.
- Reset asserted with bit_count=5 and fill=2 -> next cycle: bit_count=0, fill=0, word_valid=0, overflow=0, word_out=0. A bit_valid on the reset edge is ignored.
